loopback_marker_gen: RTL
========================

// Module: loopback_marker_gen
// PURPOSE
//  Generates the 3-word loopback MARKER frame for the TX path mux, upstream of it, on TX_CLK.
//  Accepts a request from software or the internal period timer, waits for a fiber-idle slot,
//  then drives MARKER_DATA/KCHAR with MARKER_EN high for exactly 3 cycles. Tracks a 16-bit
//  frame sequence number and counts dropped requests.
// PARAMETERS
//  PERIOD     1024   auto-marker interval in TX_CLK cycles (>= 8)
//  GAP_WORDS  4      minimum cycles with MARKER_EN low between frames (>= 1)
//  AUTO_TYPE  8'hA5  MARKER_TYPE byte used for timer-generated frames
// PORTS
//  TX_CLK        in   1   TX word clock; the only clock
//  RESET_N       in   1   asynchronous, active-low reset
//  MARKER_REQ    in   1   1-cycle request pulse; MARKER_TYPE sampled with it
//  MARKER_TYPE   in   8   marker type for external request
//  AUTO_EN       in   1   enables periodic markers from internal timer
//  FIBER_IDLE    in   1   1 = packet writer between packets; frame may start
//  MARKER_DATA   out  16  marker word to TX mux
//  MARKER_KCHAR  out  2   K flags for MARKER_DATA ([1]=upper byte, [0]=lower byte)
//  MARKER_EN     out  1   1 = mux selects MARKER_DATA/KCHAR
//  MARKER_BUSY   out  1   1 = request pending or frame/gap in progress
//  MARKER_SEQ    out  16  sequence number of next frame to send
//  DROP_CNT      out  8   saturating count of requests lost while one was pending
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, FSM IDLE, pending clear, timer 0, SEQ 0.
//  Frame: W0={8'h1C,8'hBC} K=2'b11; W1=SEQ K=2'b00; W2={TYPE, TYPE^SEQ[15:8]^SEQ[7:0]} K=2'b00.
//  Outputs registered; MARKER_DATA/KCHAR = 0 whenever MARKER_EN = 0.
//  Pending: 1-deep flag + latched TYPE. Set by MARKER_REQ or timer tick; cleared on W0 issue.
//  Request while pending already set (or arriving same cycle it's set by other source):
//   external REQ and tick same cycle -> one request, external TYPE, no drop.
//   REQ/tick while pending=1 -> discarded, DROP_CNT+1 (saturates at 255).
//   REQ during SEND/GAP with pending=0 -> accepted into pending; not a drop.
//  FSM: IDLE -> W0 when (pending | REQ | tick) & FIBER_IDLE; W0 -> W1 -> W2 -> GAP (always);
//   GAP holds GAP_WORDS cycles then IDLE. FIBER_IDLE checked only in IDLE; ignored mid-frame.
//  Latency: REQ sampled at edge e with FIBER_IDLE=1 in IDLE -> MARKER_EN=1, W0 after edge e.
//  SEQ increments (wraps 16'hFFFF -> 0) on the edge leaving W2; W1/W2 use pre-increment value.
//  Timer: counts 0..PERIOD-1 while AUTO_EN=1; tick at PERIOD-1 then 0; AUTO_EN=0 clears to 0.
//  MARKER_BUSY = pending | (state != IDLE).
//  Reset mid-frame: MARKER_EN drops asynchronously; no partial frame resumed after release.
// STRUCTURE
//  Package tx_marker_pkg: K28_0 (8'h1C), K28_5 (8'hBC), FSM state enum
//   {IDLE,W0,W1,W2,GAP}, frame length constant 3.
//  Sub-module marker_period_timer (PERIOD param; AUTO_EN in, TICK out); rest in one file.
// TESTING
//  1 REQ, TYPE=8'h5A, FIBER_IDLE=1, SEQ=0 -> next 3 cycles 16'h1CBC/11, 16'h0000/00,
//     16'h5A5A/00; then SEQ=1, EN low >=4 cycles.
//  2 FIBER_IDLE=0 for 20 cycles after REQ -> EN stays 0, BUSY=1; W0 on edge FIBER_IDLE=1
//     sampled.
//  3 REQ during W1, then REQ during GAP -> one extra frame follows GAP, DROP_CNT=1.
//  4 AUTO_EN=1, PERIOD=16, FIBER_IDLE=1 -> W0 every 16 cycles with TYPE 8'hA5; REQ same cycle
//     as tick -> external TYPE, DROP_CNT unchanged.
//  5 RESET_N low during W1 -> EN/DATA 0 at once; after release SEQ=0, no residual frame.
//  6 Preload SEQ=16'hFFFF via 65535 frames (or force) -> W1=16'hFFFF, then SEQ=0; 300 drops
//     -> DROP_CNT=255.

Source files
------------

// File: rtl/tx_marker_pkg.sv
// Shared constants and state type for the loopback MARKER frame generator.
package tx_marker_pkg;

  localparam logic [7:0] K28_0       = 8'h1C;
  localparam logic [7:0] K28_5       = 8'hBC;
  localparam int         FRAME_WORDS = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    W1   = 3'd2,
    W2   = 3'd3,
    GAP  = 3'd4
  } marker_state_e;

  // Check byte of W2: the type folded with both sequence bytes.
  function automatic logic [7:0] marker_check(input logic [7:0] mtype, input logic [15:0] seq);
    return mtype ^ seq[15:8] ^ seq[7:0];
  endfunction

endpackage

// File: rtl/marker_period_timer.sv
// Free-running auto-marker interval timer; tick_o is high on the last count of each period.
module marker_period_timer #(
  parameter int PERIOD = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic auto_en_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!auto_en_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = auto_en_i && (cnt_q == LAST);

endmodule

// File: rtl/loopback_marker_gen.sv
// Loopback MARKER frame generator: queues one request, waits for a fiber-idle slot,
// emits the 3-word frame, then enforces an inter-frame gap.
module loopback_marker_gen
  import tx_marker_pkg::*;
#(
  parameter int         PERIOD    = 1024,
  parameter int         GAP_WORDS = 4,
  parameter logic [7:0] AUTO_TYPE = 8'hA5
) (
  input  logic          TX_CLK,
  input  logic          RESET_N,
  input  logic          MARKER_REQ,
  input  logic [7:0]    MARKER_TYPE,
  input  logic          AUTO_EN,
  input  logic          FIBER_IDLE,
  output logic [15:0]   MARKER_DATA,
  output logic [1:0]    MARKER_KCHAR,
  output logic          MARKER_EN,
  output logic          MARKER_BUSY,
  output logic [15:0]   MARKER_SEQ,
  output logic [7:0]    DROP_CNT,
  output marker_state_e dbg_state_o
);

  localparam int            GW       = $clog2(GAP_WORDS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_WORDS - 1);

  marker_state_e state_q, state_d;
  logic          pending_q, pending_d;
  logic [7:0]    ptype_q, ptype_d;
  logic [7:0]    ftype_q, ftype_d;
  logic [15:0]   seq_q, seq_d;
  logic [7:0]    drop_q, drop_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    kchar_q, kchar_d;
  logic          en_q, en_d;
  logic          tick, req_any, issue;
  logic [7:0]    new_type;

  marker_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk_i     (TX_CLK),
    .rst_ni    (RESET_N),
    .auto_en_i (AUTO_EN),
    .tick_o    (tick)
  );

  // A simultaneous external request and timer tick merge into one external request.
  assign req_any  = MARKER_REQ | tick;
  assign new_type = MARKER_REQ ? MARKER_TYPE : AUTO_TYPE;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ptype_d   = ptype_q;
    ftype_d   = ftype_q;
    seq_d     = seq_q;
    drop_d    = drop_q;
    gap_d     = gap_q;
    data_d    = '0;
    kchar_d   = '0;
    en_d      = 1'b0;
    issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if ((pending_q || req_any) && FIBER_IDLE) begin
          state_d = W0;
          issue   = 1'b1;
        end
      end
      W0: state_d = W1;
      W1: state_d = W2;
      W2: begin
        state_d = GAP;
        gap_d   = '0;
        seq_d   = seq_q + 16'd1;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (req_any && pending_q && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
    if (issue) begin
      pending_d = 1'b0;
      ftype_d   = pending_q ? ptype_q : new_type;
    end else if (req_any && !pending_q) begin
      pending_d = 1'b1;
      ptype_d   = new_type;
    end

    // Word registers are loaded from the next state so the frame appears one edge after issue.
    case (state_d)
      W0: begin
        en_d    = 1'b1;
        data_d  = {K28_0, K28_5};
        kchar_d = 2'b11;
      end
      W1: begin
        en_d   = 1'b1;
        data_d = seq_q;
      end
      W2: begin
        en_d   = 1'b1;
        data_d = {ftype_q, marker_check(ftype_q, seq_q)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge TX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      ptype_q   <= '0;
      ftype_q   <= '0;
      seq_q     <= '0;
      drop_q    <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      kchar_q   <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptype_q   <= ptype_d;
      ftype_q   <= ftype_d;
      seq_q     <= seq_d;
      drop_q    <= drop_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      kchar_q   <= kchar_d;
      en_q      <= en_d;
    end
  end

  assign MARKER_DATA  = data_q;
  assign MARKER_KCHAR = kchar_q;
  assign MARKER_EN    = en_q;
  assign MARKER_BUSY  = pending_q | (state_q != IDLE);
  assign MARKER_SEQ   = seq_q;
  assign DROP_CNT     = drop_q;
  assign dbg_state_o  = state_q;

endmodule
